bcd_display_ctrl: RTL

- Sequential controller for the 4-digit seven-segment result display of the calculator.
- Accepts a 16-bit binary value on a load pulse and converts it to 4 BCD digits with an iterative shift-add-3 engine, one bit per clock.
- Double-buffers the result and time-multiplexes the digits onto the shared BCD/anode bus feeding the segment decoder.
- Sits between the multiplier/ALU result path and the BCD-to-segment decoder.

---
 rtl/bcd_disp_pkg.sv | 10 +
 rtl/bcd_add3_shift.sv | 21 ++
 rtl/bcd_display_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the seven-segment result display controller.
package bcd_disp_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  localparam logic [3:0] CODE_O     = 4'h0;
  localparam logic [3:0] CODE_F     = 4'hF;
  localparam logic [3:0] CODE_BLANK = 4'hD;
  localparam int         BCD_MAX    = 9999;
  localparam int         SCAN_DIV_DEFAULT = 50000;
endpackage

// File: rtl/bcd_add3_shift.sv
// One double-dabble step: add 3 to every nibble >= 5, then shift left taking in one bit.
module bcd_add3_shift
  import bcd_disp_pkg::*;
#(
  parameter int NIBS = 5
) (
  input  logic [4*NIBS-1:0] i_scratch,
  input  logic              i_bit,
  output logic [4*NIBS-1:0] o_scratch
);
  logic [4*NIBS-1:0] w_adj;

  always_comb begin
    w_adj = i_scratch;
    for (int n = 0; n < NIBS; n++) begin
      if (i_scratch[4*n +: 4] >= 4'd5)
        w_adj[4*n +: 4] = i_scratch[4*n +: 4] + 4'd3;
    end
    o_scratch = {w_adj[4*NIBS-2:0], i_bit};
  end
endmodule

// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD conversion with a double-buffered display register and a
// time-multiplexed digit/anode scan feeding the segment decoder.
module bcd_display_ctrl
  import bcd_disp_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WIDTH-1:0]  value,
  input  logic              err,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [DIGITS-1:0] an,
  output logic [3:0]        bcd,
  output logic              dp
);
  // One spare nibble so 5-digit values convert correctly before truncation.
  localparam int NIBS  = DIGITS + 1;
  localparam int CNT_W = $clog2(WIDTH);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);

  state_t              r_state;
  logic [WIDTH-1:0]    r_shift;
  logic [4*NIBS-1:0]   r_scr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf_pend;
  logic [4*DIGITS-1:0] r_disp;
  logic                r_busy;
  logic                r_done;
  logic                r_ovf;
  logic [DIV_W-1:0]    r_div;
  logic [IDX_W-1:0]    r_idx;
  logic [DIGITS-1:0]   r_an;
  logic [3:0]          r_bcd;
  logic [4*NIBS-1:0]   w_scr_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;

  bcd_add3_shift #(.NIBS(NIBS)) u_step (
    .i_scratch (r_scr),
    .i_bit     (r_shift[WIDTH-1]),
    .o_scratch (w_scr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_disp     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_shift    <= value;
            r_scr      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= (32'(value) > 32'(BCD_MAX));
            r_busy     <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_scr   <= w_scr_nxt;
          r_shift <= {r_shift[WIDTH-2:0], 1'b0};
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH-1))
            r_state <= COMMIT;
        end
        COMMIT: begin
          r_disp  <= r_scr[4*DIGITS-1:0];
          r_ovf   <= r_ovf_pend;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  function automatic logic [3:0] sel_code(input logic [IDX_W-1:0]    idx,
                                          input logic [4*DIGITS-1:0] disp,
                                          input logic                off);
    if (!off)
      return disp[4*int'(idx) +: 4];
    case (int'(idx))
      3:       return CODE_O;
      2:       return CODE_F;
      1:       return CODE_F;
      default: return CODE_BLANK;
    endcase
  endfunction

  assign w_idx_nxt = (r_idx == IDX_W'(DIGITS-1)) ? '0 : r_idx + 1'b1;

  // Scan runs freely; digit content is sampled only when the index moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_idx <= '0;
      r_an  <= ~DIGITS'(1);
      r_bcd <= 4'h0;
    end else if (r_div == DIV_W'(SCAN_DIV-1)) begin
      r_div <= '0;
      r_idx <= w_idx_nxt;
      r_an  <= ~(DIGITS'(1) << w_idx_nxt);
      r_bcd <= sel_code(w_idx_nxt, r_disp, err | r_ovf);
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf;
  assign an   = r_an;
  assign bcd  = r_bcd;
  assign dp   = 1'b1;
endmodule
